// File: rtl/stm_gain_reader_if.sv
// ---------------------------------------------------------------------------
// stm_gain_reader_if
//   Bundles the pattern request handshake, the STM read port and the
//   transducer output stream of stm_gain_reader.
//
//   Signals:
//     start      request to stream one pattern (single cycle)
//     idx        pattern index, sampled with start
//     busy       pattern in flight
//     err        one-cycle pulse on a rejected start
//     done       one-cycle pulse after the last entry
//     bram_addr  STM read-port address
//     bram_dout  STM read-port data (2-cycle latency)
//     intensity  entry [15:8]
//     phase      entry [7:0]
//     tr_idx     transducer index of the current output
//     valid      intensity/phase/tr_idx valid
//
//   Modports:
//     master  the system side: requester, STM memory and stream consumer
//     slave   the reader itself
// ---------------------------------------------------------------------------
interface stm_gain_reader_if #(
  parameter int RD_ADDR_WIDTH = 16
) ();

  logic                     start;
  logic [15:0]              idx;
  logic                     busy;
  logic                     err;
  logic                     done;
  logic [RD_ADDR_WIDTH-1:0] bram_addr;
  logic [63:0]              bram_dout;
  logic [7:0]               intensity;
  logic [7:0]               phase;
  logic [7:0]               tr_idx;
  logic                     valid;

  // The memory's read data comes from the system side, so it is an output
  // of the master alongside the request signals.
  modport master (
    output start, idx, bram_dout,
    input  busy, err, done, bram_addr, intensity, phase, tr_idx, valid
  );

  modport slave (
    input  start, idx, bram_dout,
    output busy, err, done, bram_addr, intensity, phase, tr_idx, valid
  );

endinterface

// File: rtl/stm_gain_reader.sv
// ---------------------------------------------------------------------------
// stm_gain_reader
//   Read-side sequencer for the gain STM buffer. On an accepted start it
//   walks the 64-bit words of one pattern (4 x 16-bit entries per word,
//   entry 0 in bits [15:0], entry = {intensity, phase}) and streams one
//   transducer entry per cycle with no bubbles.
//
//   Ports:
//     clk    system clock
//     rst_n  synchronous active-low reset
//     bus    stm_gain_reader_if.slave (request, STM read port, stream out)
//
//   Timing (start sampled in cycle T, N = NUM_TRANSDUCERS):
//     busy   T+1 .. T+3+N
//     valid  T+4 .. T+3+N, tr_idx 0..N-1
//     done   T+4+N (busy already low)
// ---------------------------------------------------------------------------
module stm_gain_reader #(
  parameter int NUM_TRANSDUCERS = 249,
  parameter int GAIN_STM_SIZE   = 1024,
  parameter int RD_ADDR_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stm_gain_reader_if.slave      bus
);

  localparam int             LP_NW     = (NUM_TRANSDUCERS + 3) / 4;
  localparam logic [5:0]     LP_NW_M1  = 6'(LP_NW - 1);
  localparam logic [8:0]     LP_NT     = 9'(NUM_TRANSDUCERS);
  localparam logic [8:0]     LP_NT_M1  = 9'(NUM_TRANSDUCERS - 1);
  localparam logic [31:0]    LP_SIZE   = 32'(GAIN_STM_SIZE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  // Pattern base address: idx*64, truncated to the read-port width.
  function automatic logic [RD_ADDR_WIDTH-1:0] f_base_addr(input logic [15:0] i_idx);
    logic [RD_ADDR_WIDTH+21:0] wide;
    wide = {{RD_ADDR_WIDTH{1'b0}}, i_idx, 6'd0};
    return wide[RD_ADDR_WIDTH-1:0];
  endfunction

  logic [1:0]               r_state;
  logic                     r_busy;
  logic [RD_ADDR_WIDTH-1:0] r_addr;
  logic [5:0]               r_word;
  logic [1:0]               r_sub;
  logic [1:0]               r_tag;
  logic [47:0]              r_shift;
  logic [1:0]               r_rem;
  logic [8:0]               r_tr_cnt;
  logic                     r_valid;
  logic [7:0]               r_intensity;
  logic [7:0]               r_phase;
  logic [7:0]               r_tr_idx;
  logic                     r_done;
  logic                     r_err;
  logic                     r_last;

  logic                     w_start_ok;
  logic                     w_accept;
  logic                     w_reject;
  logic                     w_fetch_end;
  logic                     w_have_entry;
  logic [15:0]              w_entry;
  logic                     w_emit;
  logic                     w_emit_last;
  logic [1:0]               w_state_nxt;

  // Request qualification and end-of-fetch detection.
  always_comb begin
    w_start_ok  = ({16'd0, bus.idx} < LP_SIZE);
    w_accept    = (r_state == S_IDLE) && bus.start && w_start_ok;
    w_reject    = (r_state == S_IDLE) && bus.start && !w_start_ok;
    w_fetch_end = (r_state == S_FETCH) && (r_sub == 2'd3) && (r_word == LP_NW_M1);
  end

  // Entry selection: a freshly arrived word supplies entry 0, otherwise the
  // shift register supplies the remaining entries of the previous word.
  // Entries past the last transducer are dropped.
  always_comb begin
    w_have_entry = 1'b0;
    w_entry      = 16'd0;
    if (r_tag[1]) begin
      w_have_entry = 1'b1;
      w_entry      = bus.bram_dout[15:0];
    end else if (r_rem != 2'd0) begin
      w_have_entry = 1'b1;
      w_entry      = r_shift[15:0];
    end else begin
      w_have_entry = 1'b0;
      w_entry      = 16'd0;
    end
    w_emit      = w_have_entry && (r_tr_cnt < LP_NT);
    w_emit_last = w_emit && (r_tr_cnt == LP_NT_M1);
  end

  // Next-state logic. r_last is high in the cycle the final entry is on the
  // outputs, so moving to FIN on it places done exactly one cycle later.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (w_fetch_end) begin
          if (r_last) begin
            w_state_nxt = S_FIN;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (r_last) begin
          w_state_nxt = S_FIN;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM, address generation and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_addr  <= {RD_ADDR_WIDTH{1'b0}};
      r_word  <= 6'd0;
      r_sub   <= 2'd0;
      r_tag   <= 2'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_DRAIN);
      r_done  <= (w_state_nxt == S_FIN);
      r_err   <= w_reject;
      r_last  <= w_emit_last;
      // Tag the first cycle of each held address; two stages line the tag
      // up with the memory's read data.
      r_tag   <= {r_tag[0], (r_state == S_FETCH) && (r_sub == 2'd0)};
      if (w_accept) begin
        r_addr <= f_base_addr(bus.idx);
        r_word <= 6'd0;
        r_sub  <= 2'd0;
      end else if (r_state == S_FETCH) begin
        r_sub <= r_sub + 2'd1;
        if ((r_sub == 2'd3) && !w_fetch_end) begin
          r_addr <= r_addr + RD_ADDR_WIDTH'(1);
          r_word <= r_word + 6'd1;
        end else begin
          r_addr <= r_addr;
          r_word <= r_word;
        end
      end else begin
        r_addr <= r_addr;
        r_word <= r_word;
        r_sub  <= r_sub;
      end
    end
  end

  // Word unpacking and the registered output stream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift     <= 48'd0;
      r_rem       <= 2'd0;
      r_tr_cnt    <= 9'd0;
      r_valid     <= 1'b0;
      r_intensity <= 8'd0;
      r_phase     <= 8'd0;
      r_tr_idx    <= 8'd0;
    end else begin
      if (r_tag[1]) begin
        r_shift <= bus.bram_dout[63:16];
        r_rem   <= 2'd3;
      end else if (r_rem != 2'd0) begin
        r_shift <= {16'd0, r_shift[47:16]};
        r_rem   <= r_rem - 2'd1;
      end else begin
        r_shift <= r_shift;
        r_rem   <= r_rem;
      end

      if (w_accept) begin
        r_tr_cnt <= 9'd0;
      end else if (w_emit) begin
        r_tr_cnt <= r_tr_cnt + 9'd1;
      end else begin
        r_tr_cnt <= r_tr_cnt;
      end

      if (w_emit) begin
        r_valid     <= 1'b1;
        r_intensity <= w_entry[15:8];
        r_phase     <= w_entry[7:0];
        r_tr_idx    <= r_tr_cnt[7:0];
      end else begin
        r_valid     <= 1'b0;
        r_intensity <= r_intensity;
        r_phase     <= r_phase;
        r_tr_idx    <= r_tr_idx;
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.err       = r_err;
  assign bus.done      = r_done;
  assign bus.bram_addr = r_addr;
  assign bus.intensity = r_intensity;
  assign bus.phase     = r_phase;
  assign bus.tr_idx    = r_tr_idx;
  assign bus.valid     = r_valid;

endmodule

// File: tb/tb_stm_gain_reader.sv
// ---------------------------------------------------------------------------
// tb_stm_gain_reader
//   Two reader instances: g_dut[0] with the default 249 transducers and
//   g_dut[1] with 256. Each has a 2-cycle-latency STM read model whose
//   contents are a pure function of the address, a cycle-level reference
//   model of the streaming contract, and a per-cycle compare process.
//   Directed stimulus plus hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_stm_gain_reader;

  logic        clk;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;

  logic        rst_s   [2];
  logic        start_s [2];
  logic [15:0] idx_s   [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s[%0d] cyc=%0d got=%0h want=%0h", name, g, cyc, act, exp);
    end
  endtask

  // STM contents: pattern 3 entry i = {i, ~i}; other patterns use a
  // pattern-dependent scramble so a wrong base address shows up.
  function automatic logic [15:0] entry(input int p, input int i);
    logic [7:0] iv;
    iv = 8'(i);
    if (p == 3) return {iv, ~iv};
    else        return {iv + 8'(p * 37), iv ^ 8'(p * 11 + 5)};
  endfunction

  function automatic logic [63:0] mem_word(input logic [15:0] a);
    int p;
    int w;
    p = int'(a >> 6);
    w = int'(a & 16'd63);
    return {entry(p, 4*w+3), entry(p, 4*w+2), entry(p, 4*w+1), entry(p, 4*w)};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int NT = (g == 0) ? 249 : 256;
    localparam int NW = (NT + 3) / 4;

    stm_gain_reader_if #(.RD_ADDR_WIDTH(16)) u_if ();

    logic [15:0] a1_q;
    logic [63:0] dout_q;

    assign u_if.start     = start_s[g];
    assign u_if.idx       = idx_s[g];
    assign u_if.bram_dout = dout_q;

    stm_gain_reader #(
      .NUM_TRANSDUCERS(NT),
      .GAIN_STM_SIZE  (1024),
      .RD_ADDR_WIDTH  (16)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_s[g]),
      .bus  (u_if.slave)
    );

    // Memory read port: address register then output register.
    always @(posedge clk) begin
      a1_q   <= u_if.bram_addr;
      dout_q <= mem_word(a1_q);
    end

    // Reference model: remembers the accepted start cycle and pattern.
    int m_cyc  = 0;
    int m_t    = 0;
    int m_pat  = 0;
    bit m_have = 1'b0;
    bit m_rst  = 1'b0;
    bit m_err  = 1'b0;

    always @(posedge clk) begin
      m_rst = 1'b0;
      m_err = 1'b0;
      if (!rst_s[g]) begin
        m_have = 1'b0;
        m_rst  = 1'b1;
      end else if (start_s[g] && !(m_have && (m_cyc - m_t) <= NT + 4)) begin
        if (idx_s[g] < 16'd1024) begin
          m_have = 1'b1;
          m_t    = m_cyc;
          m_pat  = int'(idx_s[g]);
        end else begin
          m_err = 1'b1;
        end
      end
      m_cyc = m_cyc + 1;
    end

    int          k;
    logic        e_busy;
    logic        e_valid;
    logic        e_done;
    logic [15:0] e_addr;
    logic [15:0] e_ent;

    always @(negedge clk) begin
      if (m_cyc >= 1) begin
        k       = m_cyc - m_t;
        e_busy  = m_have && (k >= 1) && (k <= NT + 3);
        e_valid = m_have && (k >= 4) && (k <= NT + 3);
        e_done  = m_have && (k == NT + 4);
        if (!m_have)          e_addr = 16'd0;
        else if (k <= 4 * NW) e_addr = 16'(m_pat * 64 + (k - 1) / 4);
        else                  e_addr = 16'(m_pat * 64 + NW - 1);
        check("busy",      g, 32'(u_if.busy),      32'(e_busy));
        check("valid",     g, 32'(u_if.valid),     32'(e_valid));
        check("done",      g, 32'(u_if.done),      32'(e_done));
        check("err",       g, 32'(u_if.err),       32'(m_err));
        check("bram_addr", g, 32'(u_if.bram_addr), 32'(e_addr));
        if (e_valid) begin
          e_ent = entry(m_pat, k - 4);
          check("tr_idx",    g, 32'(u_if.tr_idx),    32'(k - 4));
          check("intensity", g, 32'(u_if.intensity), 32'(e_ent[15:8]));
          check("phase",     g, 32'(u_if.phase),     32'(e_ent[7:0]));
        end
        if (m_rst) begin
          check("rst_tr_idx",    g, 32'(u_if.tr_idx),    32'd0);
          check("rst_intensity", g, 32'(u_if.intensity), 32'd0);
          check("rst_phase",     g, 32'(u_if.phase),     32'd0);
        end
      end
    end
  end

  // Advance to just after the rising edge that opens cycle c.
  task automatic drive_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int g, input int c, input logic [15:0] id);
    drive_to(c);
    start_s[g] = 1'b1;
    idx_s[g]   = id;
    drive_to(c + 1);
    start_s[g] = 1'b0;
  endtask

  task automatic at_neg(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Stimulus.
  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_s[i]   = 1'b0;
      start_s[i] = 1'b0;
      idx_s[i]   = 16'd0;
    end
    drive_to(4);
    rst_s[0] = 1'b1;
    rst_s[1] = 1'b1;
    fork
      begin
        pulse_start(0, 10, 16'd3);      // pattern 3
        pulse_start(0, 60, 16'd7);      // ignored while busy
        pulse_start(0, 270, 16'd1024);  // out of range
        pulse_start(0, 280, 16'd0);     // back-to-back pair
        pulse_start(0, 533, 16'd2);     // FIN cycle: ignored
        pulse_start(0, 534, 16'd1);
        pulse_start(0, 800, 16'd3);     // aborted by reset
        drive_to(900);
        rst_s[0] = 1'b0;
        drive_to(901);
        rst_s[0] = 1'b1;
        pulse_start(0, 910, 16'd3);
      end
      begin
        pulse_start(1, 20, 16'd2);
      end
    join
  end

  // Hand-computed expectations, default build.
  initial begin
    at_neg(5);
    check("L_rst_busy", 0, 32'(g_dut[0].u_if.busy),      32'd0);
    check("L_rst_addr", 0, 32'(g_dut[0].u_if.bram_addr), 32'd0);
    check("L_rst_int",  0, 32'(g_dut[0].u_if.intensity), 32'd0);
    at_neg(11);
    check("L_addr_first", 0, 32'(g_dut[0].u_if.bram_addr), 32'd192);
    at_neg(14);
    check("L_first_valid", 0, 32'(g_dut[0].u_if.valid),  32'd1);
    check("L_first_ph",    0, 32'(g_dut[0].u_if.phase),  32'hFF);
    at_neg(24);
    check("L_tr10_idx", 0, 32'(g_dut[0].u_if.tr_idx),    32'd10);
    check("L_tr10_int", 0, 32'(g_dut[0].u_if.intensity), 32'h0A);
    check("L_tr10_ph",  0, 32'(g_dut[0].u_if.phase),     32'hF5);
    at_neg(259);
    check("L_addr_last", 0, 32'(g_dut[0].u_if.bram_addr), 32'd254);
    at_neg(262);
    check("L_last_idx", 0, 32'(g_dut[0].u_if.tr_idx),    32'd248);
    check("L_last_int", 0, 32'(g_dut[0].u_if.intensity), 32'hF8);
    check("L_last_ph",  0, 32'(g_dut[0].u_if.phase),     32'h07);
    at_neg(263);
    check("L_done",      0, 32'(g_dut[0].u_if.done),  32'd1);
    check("L_done_nval", 0, 32'(g_dut[0].u_if.valid), 32'd0);
    check("L_done_busy", 0, 32'(g_dut[0].u_if.busy),  32'd0);
    at_neg(271);
    check("L_err",      0, 32'(g_dut[0].u_if.err),       32'd1);
    check("L_err_addr", 0, 32'(g_dut[0].u_if.bram_addr), 32'd254);
    at_neg(272);
    check("L_err_off", 0, 32'(g_dut[0].u_if.err), 32'd0);
    at_neg(535);
    check("L_p1_addr", 0, 32'(g_dut[0].u_if.bram_addr), 32'd64);
    at_neg(538);
    check("L_p1_int", 0, 32'(g_dut[0].u_if.intensity), 32'h25);
    check("L_p1_ph",  0, 32'(g_dut[0].u_if.phase),     32'h10);
    at_neg(783);
    check("L_p1_addr_last", 0, 32'(g_dut[0].u_if.bram_addr), 32'd126);
    at_neg(787);
    check("L_p1_done", 0, 32'(g_dut[0].u_if.done), 32'd1);
    at_neg(901);
    check("L_abort_valid", 0, 32'(g_dut[0].u_if.valid),     32'd0);
    check("L_abort_busy",  0, 32'(g_dut[0].u_if.busy),      32'd0);
    check("L_abort_addr",  0, 32'(g_dut[0].u_if.bram_addr), 32'd0);
    at_neg(914);
    check("L_restart_valid", 0, 32'(g_dut[0].u_if.valid),  32'd1);
    check("L_restart_idx",   0, 32'(g_dut[0].u_if.tr_idx), 32'd0);
    at_neg(1163);
    check("L_restart_done", 0, 32'(g_dut[0].u_if.done), 32'd1);
  end

  // Hand-computed expectations, 256-transducer build (pattern 2 at cycle 20).
  initial begin
    at_neg(21);
    check("L256_addr_first", 1, 32'(g_dut[1].u_if.bram_addr), 32'd128);
    at_neg(273);
    check("L256_addr_last", 1, 32'(g_dut[1].u_if.bram_addr), 32'd191);
    at_neg(279);
    check("L256_last_idx", 1, 32'(g_dut[1].u_if.tr_idx),    32'd255);
    check("L256_last_int", 1, 32'(g_dut[1].u_if.intensity), 32'h49);
    check("L256_last_ph",  1, 32'(g_dut[1].u_if.phase),     32'hE4);
    at_neg(280);
    check("L256_done", 1, 32'(g_dut[1].u_if.done),  32'd1);
    check("L256_nval", 1, 32'(g_dut[1].u_if.valid), 32'd0);
    at_neg(281);
    check("L256_done_off", 1, 32'(g_dut[1].u_if.done), 32'd0);
  end

  // End of run.
  initial begin
    at_neg(1200);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
